// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small write FIFO feeding a start/data/parity/stop
// serialiser that sends queued frames back-to-back without idle gaps.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_L,
   input  logic                          i_Tx_DV,
   input  logic [DATA_BITS-1:0]          i_Tx_Byte,
   output logic                          o_Tx_Ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
   output logic                          o_Overflow,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Done,
   output logic [2:0]                    o_Fsm_State
);

   // Write handshake: an entry is stored on a rising edge where i_Tx_DV && o_Tx_Ready;
   // i_Tx_DV while !o_Tx_Ready drops the data and pulses o_Overflow the next cycle.
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic                 ovf_q, ovf_d;

   state_t               state_q, state_d;
   logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   logic                 full, wr_en, pop, have_data, bit_end, head_par;
   logic [DATA_BITS-1:0] head;

   // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
   assign full      = (count_q == CNTW'(FIFO_DEPTH));
   assign wr_en     = i_Tx_DV && !full;
   assign have_data = (count_q != '0);
   assign head      = mem_q[rd_ptr_q];
   assign head_par  = (PARITY == 1) ? ~^head : ^head;
   assign bit_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CNTW'(wr_en) - CNTW'(pop);
      ovf_d    = i_Tx_DV && full;
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      serial_d  = serial_q;
      active_d  = active_q;
      done_d    = 1'b0;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            serial_d  = 1'b1;
            active_d  = 1'b0;
            clk_cnt_d = '0;
            bit_d     = '0;
            if (have_data) begin
               pop      = 1'b1;
               shift_d  = head;
               par_d    = head_par;
               serial_d = 1'b0;
               active_d = 1'b1;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_d     = '0;
               serial_d  = shift_q[0];
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     serial_d = par_q;
                     state_d  = S_PARITY;
                  end else begin
                     serial_d = 1'b1;
                     state_d  = S_STOP;
                  end
               end else begin
                  bit_d    = bit_q + BW'(1);
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_d     = '0;
               serial_d  = 1'b1;
               state_d   = S_STOP;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  // Chain straight into the next start bit when more data is queued.
                  if (have_data) begin
                     pop      = 1'b1;
                     shift_d  = head;
                     par_d    = head_par;
                     serial_d = 1'b0;
                     state_d  = S_START;
                  end else begin
                     serial_d = 1'b1;
                     active_d = 1'b0;
                     state_d  = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            serial_d  = 1'b1;
            active_d  = 1'b0;
            clk_cnt_d = '0;
            bit_d     = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= i_Tx_Byte;
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         serial_q  <= serial_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   assign o_Tx_Ready   = !full;
   assign o_Fifo_Count = count_q;
   assign o_Overflow   = ovf_q;
   assign o_Tx_Active  = active_q;
   assign o_Tx_Serial  = serial_q;
   assign o_Tx_Done    = done_q;
   assign o_Fsm_State  = state_q;

endmodule
